cpu_mem_bus: RTL and testbench
==============================

Name: cpu_mem_bus

Overview:
Memory and I/O subsystem directly downstream of cpu_core. It decodes the core's 16-bit address bus and returns read data on din. It provides writable RAM, a program ROM loadable through a side port, GPIO registers, and a prescaled down-counting timer with an interrupt. It replaces the bench-level ROM array as the core's data source in the synthesizable top level.

Parameters:
RAM_AW, 10, RAM address width; RAM spans 0x0000 to 2^RAM_AW-1.
ROM_AW, 12, ROM address width; ROM occupies the top 2^ROM_AW bytes (0xF000-0xFFFF at default).
IO_BASE, 16'h8000, base of 16-byte I/O window (IO_BASE to IO_BASE+0xF).
PRESCALE, 16, clk cycles per timer tick; legal range 1-65535.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
addr  in  16  address from cpu_core
dout  in  8  write data from cpu_core
we  in  1  write strobe from cpu_core, sampled on rising clk
din  out  8  read data to cpu_core, combinational from addr
gpio_in  in  8  external inputs, asynchronous to clk
gpio_out  out  8  GPIO output register
irq  out  1  timer interrupt, level, active-high
prog_we  in  1  ROM program write strobe
prog_addr  in  ROM_AW  ROM program address
prog_data  in  8  ROM program data

Behaviour:
- Decode priority: RAM, then IO window, then ROM, else unmapped. Unmapped reads return 8'hFF; unmapped writes are ignored.
- Reads are combinational. din follows addr (and the register/memory contents) within the same cycle. Reads have no side effects.
- RAM: when we=1 and addr is in RAM, mem[addr] <= dout at the clk edge. Not cleared by reset. Read-during-write returns old data until the edge.
- ROM: CPU writes are ignored. When prog_we=1, rom[prog_addr] <= prog_data at the clk edge, independent of addr/we and of reset state. Not cleared by reset.
- IO map (offset from IO_BASE):
  - 0x0 GPIO_OUT (RW).
  - 0x1 GPIO_IN (RO). Two-flop synchronized gpio_in, so a change is visible 2 clk edges later.
  - 0x2 RELOAD_LO (RW).
  - 0x3 RELOAD_HI (RW).
  - 0x4 COUNT_LO (RO).
  - 0x5 COUNT_HI (RO).
  - 0x6 CTRL (RW): bit0 EN, bit1 IRQ_EN, other bits read 0.
  - 0x7 STATUS: bit0 UF flag; write 1 to clear, write 0 has no effect.
  - 0x8-0xF read 0x00, writes ignored.
- Reset values: gpio_out=0x00, sync flops=0x00, RELOAD=0xFFFF, COUNT=0xFFFF, prescaler=0, CTRL=0x00, UF=0, irq=0.
- Prescaler counts 0..PRESCALE-1 while EN=1. It emits a tick on the cycle it equals PRESCALE-1, then wraps to 0. While EN=0 it holds.
- On tick: if COUNT==0, COUNT<=RELOAD and UF<=1; else COUNT<=COUNT-1. Underflow period is (RELOAD+1)*PRESCALE cycles.
- Write to CTRL that changes EN 0->1: COUNT<=RELOAD and prescaler<=0 at that edge.
- Writing RELOAD while running does not disturb COUNT; it takes effect at the next reload.
- Simultaneous STATUS clear and underflow in the same cycle: set wins, UF=1.
- irq = UF & IRQ_EN, driven combinationally from registers. Clearing IRQ_EN masks irq but UF is kept.
- Asynchronous reset mid-count returns all timer/IO state to reset values immediately. The timer stays stopped until EN is written.

Test Plan:
1. RAM: write 0x5A to 0x0010, then 0xA5 to 0x03FF; read back -> din=0x5A, 0xA5. Read 0x0400 (unmapped) -> 0xFF.
2. ROM: prog_we writes 0xA9 at prog_addr 0x000 and 0x03 at 0x001. CPU reads 0xF000/0xF001 -> 0xA9/0x03. CPU write 0x00 to 0xF000 -> still reads 0xA9.
3. GPIO: write 0x3C to 0x8000 -> gpio_out=0x3C. Set gpio_in=0x81 -> 0x8001 reads 0x00 after 1 edge and 0x81 after 2 edges.
4. Timer (PRESCALE=2): RELOAD=0x0003, write CTRL=0x03 -> UF=1 and irq=1 exactly 8 cycles after the CTRL write edge; COUNT reads 0x0003 after the reload.
5. Collision: write 0x01 to STATUS on the underflow cycle -> UF stays 1. Write 0x01 one cycle later -> UF=0, irq=0.
6. Reset: assert reset asynchronously with COUNT=0x0001 and gpio_out=0x3C -> immediately COUNT=0xFFFF, gpio_out=0x00, irq=0. RAM contents written before reset read back unchanged.

Source files
------------

// File: rtl/cpu_mem_bus.sv
// Address decode, RAM/ROM storage, GPIO and a prescaled down-counting timer
// sitting between cpu_core and the rest of the system.
module cpu_mem_bus #(
  parameter int          RAM_AW   = 10,
  parameter int          ROM_AW   = 12,
  parameter logic [15:0] IO_BASE  = 16'h8000,
  parameter int          PRESCALE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [7:0]        dout,
  input  logic              we,
  output logic [7:0]        din,
  input  logic [7:0]        gpio_in,
  output logic [7:0]        gpio_out,
  output logic              irq,
  input  logic              prog_we,
  input  logic [ROM_AW-1:0] prog_addr,
  input  logic [7:0]        prog_data
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [7:0] ram_q [2**RAM_AW];
  logic [7:0] rom_q [2**ROM_AW];

  logic [7:0]  gpio_out_q, gpio_out_d;
  logic [7:0]  sync1_q, sync1_d;
  logic [7:0]  sync2_q, sync2_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        uf_q, uf_d;

  logic       ram_sel, io_sel, rom_sel, io_we, tick, underflow;
  logic [3:0] io_off;

  // RAM wins over the IO window, which wins over ROM.
  assign ram_sel   = (addr >> RAM_AW) == 16'd0;
  assign io_sel    = !ram_sel && (addr[15:4] == IO_BASE[15:4]);
  assign rom_sel   = !ram_sel && !io_sel && (&addr[15:ROM_AW]);
  assign io_off    = addr[3:0];
  assign io_we     = we && io_sel;
  assign tick      = en_q && (presc_q == PS_MAX);
  assign underflow = tick && (count_q == 16'd0);

  always_comb begin
    gpio_out_d = gpio_out_q;
    sync1_d    = gpio_in;
    sync2_d    = sync1_q;
    reload_d   = reload_q;
    count_d    = count_q;
    presc_d    = presc_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    uf_d       = uf_q;

    if (en_q) presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (tick) count_d = (count_q == 16'd0) ? reload_q : count_q - 16'd1;

    if (io_we) begin
      case (io_off)
        4'h0: gpio_out_d = dout;
        4'h2: reload_d[7:0] = dout;
        4'h3: reload_d[15:8] = dout;
        4'h6: begin
          en_d     = dout[0];
          irq_en_d = dout[1];
          // Only a rising EN restarts the period; rewriting EN=1 leaves it running.
          if (dout[0] && !en_q) begin
            count_d = reload_q;
            presc_d = 16'd0;
          end
        end
        4'h7: if (dout[0]) uf_d = 1'b0;
        default: ;
      endcase
    end

    // A flag set in the same cycle as a software clear must not be lost.
    if (underflow) uf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      reload_q   <= 16'hFFFF;
      count_q    <= 16'hFFFF;
      presc_q    <= 16'd0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      uf_q       <= uf_d;
    end
  end

  // Memories are deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (we && ram_sel) ram_q[addr[RAM_AW-1:0]] <= dout;
    if (prog_we) rom_q[prog_addr] <= prog_data;
  end

  always_comb begin
    din = 8'hFF;
    if (ram_sel) begin
      din = ram_q[addr[RAM_AW-1:0]];
    end else if (io_sel) begin
      case (io_off)
        4'h0:    din = gpio_out_q;
        4'h1:    din = sync2_q;
        4'h2:    din = reload_q[7:0];
        4'h3:    din = reload_q[15:8];
        4'h4:    din = count_q[7:0];
        4'h5:    din = count_q[15:8];
        4'h6:    din = {6'b0, irq_en_q, en_q};
        4'h7:    din = {7'b0, uf_q};
        default: din = 8'h00;
      endcase
    end else if (rom_sel) begin
      din = rom_q[addr[ROM_AW-1:0]];
    end
  end

  assign gpio_out = gpio_out_q;
  assign irq      = uf_q & irq_en_q;

endmodule

// File: tb/tb_cpu_mem_bus.sv
// Randomized bench for cpu_mem_bus against array models and closed-form timer arithmetic.
module tb_cpu_mem_bus;
  localparam int P = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  dout = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  din;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic        irq;
  logic        prog_we = 1'b0;
  logic [11:0] prog_addr = 12'h000;
  logic [7:0]  prog_data = 8'h00;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] ram_m [1024];
  logic [7:0] rom_m [4096];
  int ram_list[$];
  logic [7:0] gpio_seen = 8'h00;

  cpu_mem_bus #(.RAM_AW(10), .ROM_AW(12), .IO_BASE(16'h8000), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .addr(addr), .dout(dout), .we(we), .din(din),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; dout = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    addr = a; #1;
    d = din;
  endtask

  task automatic read16(input logic [15:0] a, output logic [15:0] v);
    logic [7:0] lo, hi;
    cpu_read(a, lo);
    cpu_read(a + 16'd1, hi);
    v = {hi, lo};
  endtask

  task automatic prog_write(input logic [11:0] a, input logic [7:0] d);
    prog_addr = a; prog_data = d; prog_we = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0;
    rom_m[a] = d;
  endtask

  task automatic ram_write(input int a, input logic [7:0] d);
    cpu_write(16'(a), d);
    ram_m[a] = d;
    ram_list.push_back(a);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic wait_irq(input int limit, output int e);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < limit) begin @(posedge clk); #1; n++; end
    e = (irq === 1'b1) ? cyc : -1;
  endtask

  task automatic timer_setup(input int r);
    cpu_write(16'h8006, 8'h00);
    cpu_write(16'h8007, 8'h01);
    cpu_write(16'h8003, 8'h00);
    cpu_write(16'h8002, 8'(r));
  endtask

  task automatic test_reset;
    logic [7:0] b; logic [15:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out got %h exp 00", gpio_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    read16(16'h8002, v);
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_reload got %h exp FFFF", v); end
    read16(16'h8004, v);
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_count got %h exp FFFF", v); end
    cpu_read(16'h8006, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", b); end
    cpu_read(16'h8007, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", b); end
    cpu_write(16'h8006, 8'hFC);
    cpu_read(16'h8006, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL ctrl_reserved got %h exp 00", b); end
    cpu_write(16'h8006, 8'h00);
  endtask

  task automatic test_ram;
    logic [7:0] b; int a;
    ram_write(16'h0010, 8'h5A);
    ram_write(16'h03FF, 8'hA5);
    addr = 16'h0010; dout = 8'h77; we = 1'b1; #1;
    checks++; if (din !== 8'h5A) begin errors++; $display("FAIL ram_read_during_write got %h exp 5A", din); end
    @(posedge clk); #1 we = 1'b0;
    ram_m[16'h0010] = 8'h77;
    cpu_read(16'h0010, b);
    checks++; if (b !== 8'h77) begin errors++; $display("FAIL ram_after_write got %h exp 77", b); end
    cpu_read(16'h03FF, b);
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL ram_top got %h exp A5", b); end
    cpu_read(16'h0400, b);
    checks++; if (b !== 8'hFF) begin errors++; $display("FAIL unmapped_0400 got %h exp FF", b); end
    ram_write(0, 8'h11);
    cpu_write(16'h0400, 8'h99);
    cpu_read(16'h0000, b);
    checks++; if (b !== 8'h11) begin errors++; $display("FAIL unmapped_write_alias got %h exp 11", b); end
    for (int i = 0; i < 16; i++) ram_write($urandom_range(0, 1023), 8'($urandom));
    foreach (ram_list[i]) begin
      cpu_read(16'(ram_list[i]), b);
      checks++; if (b !== ram_m[ram_list[i]]) begin errors++; $display("FAIL ram_random @%h got %h exp %h", ram_list[i], b, ram_m[ram_list[i]]); end
    end
    for (int i = 0; i < 8; i++) begin
      a = (i % 2 == 0) ? $urandom_range(16'h0400, 16'h7FFF) : $urandom_range(16'h8010, 16'hEFFF);
      cpu_read(16'(a), b);
      checks++; if (b !== 8'hFF) begin errors++; $display("FAIL unmapped_random @%h got %h exp FF", a, b); end
    end
  endtask

  task automatic test_rom;
    logic [7:0] b; int alist[$]; int a;
    prog_write(12'h000, 8'hA9);
    prog_write(12'h001, 8'h03);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(2, 4095);
      prog_write(12'(a), 8'($urandom));
      alist.push_back(a);
    end
    cpu_read(16'hF000, b);
    checks++; if (b !== 8'hA9) begin errors++; $display("FAIL rom_f000 got %h exp A9", b); end
    cpu_read(16'hF001, b);
    checks++; if (b !== 8'h03) begin errors++; $display("FAIL rom_f001 got %h exp 03", b); end
    cpu_write(16'hF000, 8'h00);
    cpu_read(16'hF000, b);
    checks++; if (b !== 8'hA9) begin errors++; $display("FAIL rom_cpu_write_ignored got %h exp A9", b); end
    foreach (alist[i]) begin
      cpu_read(16'hF000 | 16'(alist[i]), b);
      checks++; if (b !== rom_m[alist[i]]) begin errors++; $display("FAIL rom_random @%h got %h exp %h", alist[i], b, rom_m[alist[i]]); end
    end
  endtask

  task automatic test_gpio;
    logic [7:0] b, v;
    cpu_write(16'h8000, 8'h3C);
    checks++; if (gpio_out !== 8'h3C) begin errors++; $display("FAIL gpio_out_pin got %h exp 3C", gpio_out); end
    cpu_read(16'h8000, b);
    checks++; if (b !== 8'h3C) begin errors++; $display("FAIL gpio_out_read got %h exp 3C", b); end
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 8'h81 : 8'($urandom);
      gpio_in = v;
      @(posedge clk); #1;
      cpu_read(16'h8001, b);
      checks++; if (b !== gpio_seen) begin errors++; $display("FAIL gpio_in_one_edge got %h exp %h", b, gpio_seen); end
      @(posedge clk); #1;
      cpu_read(16'h8001, b);
      checks++; if (b !== v) begin errors++; $display("FAIL gpio_in_two_edges got %h exp %h", b, v); end
      gpio_seen = v;
    end
    for (int i = 8; i < 16; i++) begin
      cpu_write(16'h8000 + 16'(i), 8'($urandom));
      cpu_read(16'h8000 + 16'(i), b);
      checks++; if (b !== 8'h00) begin errors++; $display("FAIL io_reserved @%0d got %h exp 00", i, b); end
    end
  endtask

  task automatic test_timer;
    logic [7:0] b; logic [15:0] v; int r, r2, e0, e1, e2, ex;
    for (int it = 0; it < 4; it++) begin
      r  = (it == 0) ? 3 : $urandom_range(0, 5);
      r2 = (it == 0) ? 3 : $urandom_range(0, 5);
      timer_setup(r);
      cpu_write(16'h8006, 8'h03);
      e0 = cyc;
      read16(16'h8004, v);
      checks++; if (v !== 16'(r)) begin errors++; $display("FAIL timer_start_count got %h exp %h", v, r); end
      cpu_write(16'h8002, 8'(r2));
      read16(16'h8004, v);
      ex = r - (cyc - e0) / P;
      checks++; if (v !== 16'(ex)) begin errors++; $display("FAIL timer_reload_write_no_disturb got %h exp %h", v, ex); end
      wait_irq(200, e1);
      checks++; if (e1 != e0 + (r + 1) * P) begin errors++; $display("FAIL timer_period1 got %0d exp %0d", e1 - e0, (r + 1) * P); end
      cpu_read(16'h8007, b);
      checks++; if (b !== 8'h01) begin errors++; $display("FAIL timer_uf_set got %h exp 01", b); end
      read16(16'h8004, v);
      checks++; if (v !== 16'(r2)) begin errors++; $display("FAIL timer_reloaded_count got %h exp %h", v, r2); end
      cpu_write(16'h8007, 8'h01);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL timer_irq_cleared got %b exp 0", irq); end
      wait_irq(200, e2);
      checks++; if (e2 != e1 + (r2 + 1) * P) begin errors++; $display("FAIL timer_period2 got %0d exp %0d", e2 - e1, (r2 + 1) * P); end
    end
  endtask

  task automatic test_collision;
    logic [7:0] b; logic [15:0] v; int e0, e;
    timer_setup(3);
    cpu_write(16'h8006, 8'h03);
    e0 = cyc;
    wait_to(e0 + 4 * P * 2 - 1);
    cpu_write(16'h8007, 8'h01);
    cpu_read(16'h8007, b);
    checks++; if (b !== 8'h01 || irq !== 1'b1) begin errors++; $display("FAIL collision_set_wins got uf=%h irq=%b exp 01/1", b, irq); end
    cpu_write(16'h8007, 8'h01);
    cpu_read(16'h8007, b);
    checks++; if (b !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL clear_after_collision got uf=%h irq=%b exp 00/0", b, irq); end
    wait_irq(200, e);
    checks++; if (e != e0 + 3 * 4 * P) begin errors++; $display("FAIL third_underflow got %0d exp %0d", e - e0, 3 * 4 * P); end
    cpu_write(16'h8006, 8'h01);
    cpu_read(16'h8007, b);
    checks++; if (irq !== 1'b0 || b !== 8'h01) begin errors++; $display("FAIL irq_mask got irq=%b uf=%h exp 0/01", irq, b); end
    cpu_write(16'h8006, 8'h03);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask got %b exp 1", irq); end
    read16(16'h8004, v);
    checks++; if (v !== 16'(3 - (cyc - e) / P)) begin errors++; $display("FAIL ctrl_rewrite_no_reload got %h exp %h", v, 3 - (cyc - e) / P); end
  endtask

  task automatic test_reset_async;
    logic [7:0] b; logic [15:0] v; int e0;
    cpu_write(16'h8000, 8'h3C);
    timer_setup(3);
    cpu_write(16'h8006, 8'h03);
    e0 = cyc;
    wait_to(e0 + 2 * P);
    read16(16'h8004, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL pre_reset_count got %h exp 0001", v); end
    #1 reset = 1'b1;
    read16(16'h8004, v);
    checks++; if (v !== 16'hFFFF || gpio_out !== 8'h00 || irq !== 1'b0) begin
      errors++; $display("FAIL async_reset got count=%h gpio=%h irq=%b exp FFFF/00/0", v, gpio_out, irq);
    end
    @(negedge clk) reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    read16(16'h8004, v);
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL timer_stopped_after_reset got %h exp FFFF", v); end
    cpu_read(16'h8006, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL ctrl_after_reset got %h exp 00", b); end
    foreach (ram_list[i]) begin
      cpu_read(16'(ram_list[i]), b);
      checks++; if (b !== ram_m[ram_list[i]]) begin errors++; $display("FAIL ram_kept @%h got %h exp %h", ram_list[i], b, ram_m[ram_list[i]]); end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rom();
    test_gpio();
    test_timer();
    test_collision();
    test_reset_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
